ysyx_22041412_ifu: RTL

//  Instruction fetch unit: producer end of the 32-bit instr interface consumed by the decode stage.

---
 rtl/ysyx_22041412_ifu.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041412_ifu.sv
// ysyx_22041412_ifu: instruction fetch unit.
// Keeps the fetch PC and issues word reads over an imem req/rsp handshake, with at
// most one request outstanding. Returned words are buffered with their PC in a small
// FIFO that feeds decode over valid/ready. A redirect flushes the FIFO, discards stale
// in-flight data and restarts fetch at the new PC.
// Optional feature: define YSYX_22041412_IFU_MISALIGN_EN to trap misaligned redirects
// (sticky misalign flag, fetch stops). Without it the low two redirect bits are ignored.
module ysyx_22041412_ifu #(
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
    output logic        misalign
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]  DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_e;

    state_e        state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic          drop_q, drop_d;
    logic [63:0]   req_pc_q;

    logic [31:0]   instr_mem_q [FIFO_DEPTH];
    logic [63:0]   pc_mem_q    [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;

    logic [63:0]   redir_pc;
    logic [CW:0]   occupancy;
    logic          space;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic          head_valid;

`ifdef YSYX_22041412_IFU_MISALIGN_EN
    logic          misalign_q;
    logic          redir_bad;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake decode: FIFO space (counting the outstanding word), push and pop strobes
    always_comb begin
`ifdef YSYX_22041412_IFU_MISALIGN_EN
        redir_pc  = redirect_pc;
        redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
        redir_pc  = redirect_pc & ~64'h3;
`endif
        head_valid = (count_q != '0);
        occupancy  = {1'b0, count_q} + {{CW{1'b0}}, (state_q == WAIT)};
        space      = (occupancy < DEPTH_C);
        req_fire   = (state_q == REQ) && imem_req_ready;
        // A response coinciding with a redirect belongs to the old stream.
        push       = (state_q == WAIT) && imem_rsp_valid && !drop_q && !redirect_valid;
        pop        = head_valid && instr_ready;
    end

    // FSM state register together with fetch PC and stale-response drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

    // FSM next state; redirect overrides all other events
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = redir_pc;
            unique case (state_q)
                IDLE: begin
                    if (!halt) state_d = REQ;
                end
                REQ: begin
                    // Accepted request now fetches an old-stream word: mark it stale.
                    if (imem_req_ready) begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d = halt ? IDLE : REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!halt && space) state_d = REQ;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state_d    = WAIT;
                        fetch_pc_d = fetch_pc_q + 64'd4;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = (!halt && space) ? REQ : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef YSYX_22041412_IFU_MISALIGN_EN
        // A misaligned target parks the unit; responses are ignored outside WAIT.
        if (misalign_q || redir_bad) begin
            state_d = IDLE;
            drop_d  = 1'b0;
        end
`endif
    end

    // FSM outputs: request toward imem and FIFO head toward decode
    always_comb begin
        imem_req_valid = (state_q == REQ);
        imem_req_addr  = fetch_pc_q;
        instr_valid    = head_valid;
        instr          = instr_mem_q[rd_ptr_q];
        instr_pc       = pc_mem_q[rd_ptr_q];
`ifdef YSYX_22041412_IFU_MISALIGN_EN
        misalign       = misalign_q;
`else
        misalign       = 1'b0;
`endif
    end

    // Remember the address of the accepted request so its word is tagged with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc_q <= '0;
        end else if (req_fire) begin
            req_pc_q <= fetch_pc_q;
        end
    end

    // Instruction/PC FIFO; redirect empties it regardless of a same-cycle pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                instr_mem_q[wr_ptr_q] <= imem_rsp_data;
                pc_mem_q[wr_ptr_q]    <= req_pc_q;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

`ifdef YSYX_22041412_IFU_MISALIGN_EN
    // Sticky misaligned-redirect flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (redir_bad) begin
            misalign_q <= 1'b1;
        end
    end
`endif

endmodule
